// File: rtl/sram_pixel_fetch.sv
// Pixel capture stage behind the SRAM read sequencer: latches RGB565 read data,
// expands it to 8:8:8, applies a colour key and tags each pixel with its draw coordinates.
module sram_pixel_fetch #(
    parameter logic [15:0] KEY_COLOR = 16'hF81F,
    parameter logic [7:0]  BG_R      = 8'h00,
    parameter logic [7:0]  BG_G      = 8'h00,
    parameter logic [7:0]  BG_B      = 8'h00,
    parameter int          STALE_W   = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        SRAM_DQ,
    input  logic [9:0]         drawxsig,
    input  logic [9:0]         drawysig,
    input  logic               blank_n,
    output logic               pix_valid,
    output logic               transparent,
    output logic [9:0]         pix_x,
    output logic [9:0]         pix_y,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic [STALE_W-1:0] stale_cnt
);

    typedef enum logic [1:0] {
        PH_INIT   = 2'd0,
        PH_ENABLE = 2'd1,
        PH_READ   = 2'd2
    } phase_e;

    phase_e             ph_q, ph_d;
    logic [9:0]         tag_x_q, tag_x_d, tag_y_q, tag_y_d;
    logic [9:0]         pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0]         col_r_q, col_r_d, col_g_q, col_g_d, col_b_q, col_b_d;
    logic               pix_valid_q, pix_valid_d;
    logic               transparent_q, transparent_d;
    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

    // Replicating the top bits fills the low end so full-scale maps to 8'hFF.
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    // Phase counter tracking the sequencer; the unused code 3 falls back to INIT.
    always_comb begin
        ph_d = PH_INIT;
        case (ph_q)
            PH_INIT:   ph_d = PH_ENABLE;
            PH_ENABLE: ph_d = PH_READ;
            PH_READ:   ph_d = PH_INIT;
            default:   ph_d = PH_INIT;
        endcase
    end

    // Coordinate tagging on the INIT edge and pixel capture on the READ edge.
    always_comb begin
        tag_x_d       = tag_x_q;
        tag_y_d       = tag_y_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        col_r_d       = col_r_q;
        col_g_d       = col_g_q;
        col_b_d       = col_b_q;
        transparent_d = transparent_q;
        stale_cnt_d   = stale_cnt_q;
        pix_valid_d   = 1'b0;

        if (ph_q == PH_INIT) begin
            tag_x_d = drawxsig;
            tag_y_d = drawysig;
        end else begin
            tag_x_d = tag_x_q;
            tag_y_d = tag_y_q;
        end

        if (ph_q == PH_READ) begin
            pix_valid_d = 1'b1;
            pix_x_d     = tag_x_q;
            pix_y_d     = tag_y_q;
            if (SRAM_DQ == KEY_COLOR) begin
                col_r_d       = BG_R;
                col_g_d       = BG_G;
                col_b_d       = BG_B;
                transparent_d = 1'b1;
            end else begin
                col_r_d       = expand5(SRAM_DQ[15:11]);
                col_g_d       = expand6(SRAM_DQ[10:5]);
                col_b_d       = expand5(SRAM_DQ[4:0]);
                transparent_d = 1'b0;
            end
            // The raster moved on since the address was issued: count it, never wrap.
            if (({drawxsig, drawysig} != {tag_x_q, tag_y_q}) && !(&stale_cnt_q)) begin
                stale_cnt_d = stale_cnt_q + {{(STALE_W-1){1'b0}}, 1'b1};
            end else begin
                stale_cnt_d = stale_cnt_q;
            end
        end else begin
            pix_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ph_q          <= PH_INIT;
            tag_x_q       <= 10'd0;
            tag_y_q       <= 10'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            col_r_q       <= 8'h00;
            col_g_q       <= 8'h00;
            col_b_q       <= 8'h00;
            pix_valid_q   <= 1'b0;
            transparent_q <= 1'b0;
            stale_cnt_q   <= {STALE_W{1'b0}};
        end else begin
            ph_q          <= ph_d;
            tag_x_q       <= tag_x_d;
            tag_y_q       <= tag_y_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            col_r_q       <= col_r_d;
            col_g_q       <= col_g_d;
            col_b_q       <= col_b_d;
            pix_valid_q   <= pix_valid_d;
            transparent_q <= transparent_d;
            stale_cnt_q   <= stale_cnt_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign transparent = transparent_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign stale_cnt   = stale_cnt_q;
    // Blanking only masks the outputs; the held pixel survives it.
    assign VGA_R       = blank_n ? col_r_q : 8'h00;
    assign VGA_G       = blank_n ? col_g_q : 8'h00;
    assign VGA_B       = blank_n ? col_b_q : 8'h00;

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// Directed bench for sram_pixel_fetch: expected pixels are queued when READ data is
// driven and popped when pix_valid is seen.
module tb_sram_pixel_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] SRAM_DQ;
    logic [9:0]  drawxsig, drawysig;
    logic        blank_n;
    logic        pix_valid, transparent;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [7:0]  stale_cnt;

    sram_pixel_fetch dut (
        .Clk(Clk), .Reset(Reset), .SRAM_DQ(SRAM_DQ),
        .drawxsig(drawxsig), .drawysig(drawysig), .blank_n(blank_n),
        .pix_valid(pix_valid), .transparent(transparent),
        .pix_x(pix_x), .pix_y(pix_y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .stale_cnt(stale_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       tr;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] cur_r, cur_g, cur_b, stale_m;
    logic       cur_tr;
    logic [9:0] cur_x, cur_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_r"}, 32'(VGA_R), blank_n ? 32'(cur_r) : 32'd0);
        chk({tag, "_g"}, 32'(VGA_G), blank_n ? 32'(cur_g) : 32'd0);
        chk({tag, "_b"}, 32'(VGA_B), blank_n ? 32'(cur_b) : 32'd0);
        chk({tag, "_tr"}, 32'(transparent), 32'(cur_tr));
        chk({tag, "_x"}, 32'(pix_x), 32'(cur_x));
        chk({tag, "_y"}, 32'(pix_y), 32'(cur_y));
        chk({tag, "_stale"}, 32'(stale_cnt), 32'(stale_m));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One INIT/ENABLE/READ slot; draw is (x0,y0) at INIT and (x1,y1) from ENABLE on.
    task automatic pixel(input logic [15:0] dq, input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1, input bit blank_mid);
        exp_t e;
        SRAM_DQ  = dq;
        drawxsig = x0;
        drawysig = y0;
        tick();
        chk("valid_enable", 32'(pix_valid), 32'd0);
        chk_out("hold_enable");
        drawxsig = x1;
        drawysig = y1;
        if (blank_mid) begin
            blank_n = 1'b0;
            #1;
            chk_out("blank_on");
        end
        tick();
        chk("valid_read", 32'(pix_valid), 32'd0);
        chk_out("hold_read");
        if (blank_mid) begin
            blank_n = 1'b1;
            #1;
            chk_out("blank_off");
        end
        if (dq == 16'hF81F) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; e.tr = 1'b1;
        end else begin
            e.r  = {dq[15:11], dq[15:13]};
            e.g  = {dq[10:5], dq[10:9]};
            e.b  = {dq[4:0], dq[4:2]};
            e.tr = 1'b0;
        end
        e.x = x0;
        e.y = y0;
        sb.push_back(e);
        if (({x1, y1} != {x0, y0}) && (stale_m != 8'hFF)) stale_m = stale_m + 8'd1;
        tick();
        chk("valid_capture", 32'(pix_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=pix_valid expected=queued_pixel");
        end else begin
            e = sb.pop_front();
            cur_r = e.r; cur_g = e.g; cur_b = e.b; cur_tr = e.tr;
            cur_x = e.x; cur_y = e.y;
            chk_out("capture");
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_tr"}, 32'(transparent), 32'd0);
        chk({tag, "_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_y"}, 32'(pix_y), 32'd0);
        chk({tag, "_rgb"}, {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk({tag, "_stale"}, 32'(stale_cnt), 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        SRAM_DQ  = 16'h0000;
        drawxsig = 10'd0;
        drawysig = 10'd0;
        blank_n  = 1'b1;
        cur_r = 8'h00; cur_g = 8'h00; cur_b = 8'h00; cur_tr = 1'b0;
        cur_x = 10'd0; cur_y = 10'd0; stale_m = 8'h00;

        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        Reset = 1'b0;

        // Capture and latency with all-ones data.
        for (int i = 0; i < 3; i++) pixel(16'hFFFF, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);
        chk("white_r", 32'(VGA_R), 32'hFF);
        chk("white_b", 32'(VGA_B), 32'hFF);

        // RGB565 expansion.
        pixel(16'h8410, 10'd1, 10'd2, 10'd1, 10'd2, 1'b0);
        chk("exp_r", 32'(VGA_R), 32'h84);
        chk("exp_g", 32'(VGA_G), 32'h82);
        chk("exp_b", 32'(VGA_B), 32'h84);
        chk("exp_tr", 32'(transparent), 32'd0);

        // Colour key, then a non-keyed pure blue.
        pixel(16'hF81F, 10'd3, 10'd4, 10'd3, 10'd4, 1'b0);
        chk("key_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("key_tr", 32'(transparent), 32'd1);
        pixel(16'h001F, 10'd3, 10'd5, 10'd3, 10'd5, 1'b0);
        chk("blue_b", 32'(VGA_B), 32'hFF);
        chk("blue_r", 32'(VGA_R), 32'h00);
        chk("blue_tr", 32'(transparent), 32'd0);

        // Coordinate tagging and stale count saturation.
        pixel(16'h1234, 10'd5, 10'd7, 10'd6, 10'd7, 1'b0);
        chk("tag_x", 32'(pix_x), 32'd5);
        chk("tag_y", 32'(pix_y), 32'd7);
        chk("stale_one", 32'(stale_cnt), 32'd1);
        for (int i = 0; i < 300; i++)
            pixel(16'(i * 37), 10'(i), 10'd1, 10'(i + 1), 10'd1, 1'b0);
        chk("stale_sat", 32'(stale_cnt), 32'd255);

        // Blanking in the middle of a slot.
        pixel(16'hFFFF, 10'd8, 10'd9, 10'd8, 10'd9, 1'b0);
        pixel(16'hFFFF, 10'd8, 10'd9, 10'd8, 10'd9, 1'b1);
        chk("unblank_r", 32'(VGA_R), 32'hFF);

        // Reset asserted during ENABLE.
        SRAM_DQ = 16'hFFFF;
        tick();
        Reset = 1'b1;
        #1;
        chk_zero("midreset");
        sb.delete();
        cur_r = 8'h00; cur_g = 8'h00; cur_b = 8'h00; cur_tr = 1'b0;
        cur_x = 10'd0; cur_y = 10'd0; stale_m = 8'h00;
        tick();
        Reset = 1'b0;
        pixel(16'h8410, 10'd2, 10'd3, 10'd2, 10'd3, 1'b0);
        chk("post_reset_g", 32'(VGA_G), 32'h82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
